// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constants, transmitter state encoding, reload helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // 12 MHz core clock divided down to 9600 baud.
  localparam int CLKS_PER_BIT_9600 = 1250;

  // Width of the per-bit baud down-counter; bounds CLKS_PER_BIT to 65535.
  localparam int BAUD_W = 16;

  // Payload bits per frame (8N1 family).
  localparam int DATA_BITS = 8;

  // Transmitter frame phases; the receiver uses the same names.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Reload value for a bit period: the counter runs reload..0 inclusive,
  // so a bit lasts exactly clks_per_bit cycles.
  function automatic logic [BAUD_W-1:0] bit_reload(input int clks_per_bit);
    return BAUD_W'(clks_per_bit - 1);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: loadable 16-bit down-counter that parks at zero and flags it.
// Latency: done asserts load_value cycles after the load edge.
// Backpressure: none; the owner decides when to reload.
module uart_baud_counter
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BAUD_W-1:0] load_value,
  output logic              done
);

  logic [BAUD_W-1:0] count;

  // Reload on a bit boundary, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The current bit ends on the edge where the counter already reads zero.
  assign done = (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART TX: serialises bytes as start + 8 data (LSB first) + STOP_BITS stop bits.
// Latency: a byte accepted at edge N while idle starts its start bit at edge N+1.
// Backpressure: ready = holding register empty; one byte can wait while a frame shifts.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock_12MHz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       busy,
  output logic       uart_tx
);

  localparam logic [BAUD_W-1:0] BIT_RELOAD = bit_reload(CLKS_PER_BIT);
  localparam logic [2:0]        LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0]        LAST_STOP  = 3'(STOP_BITS - 1);

  uart_tx_state_t state;
  uart_tx_state_t state_next;

  logic [7:0] shift;
  logic [7:0] shift_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_next;
  logic       tx_reg;
  logic       tx_next;

  logic [7:0] hold;
  logic [7:0] hold_next;
  logic       hold_full;
  logic       hold_full_next;

  logic       transfer;
  logic       start_frame;
  logic       baud_load;
  logic       bit_done;

  // A byte is taken only while the holding register is empty; data is not
  // looked at otherwise, so X on an idle bus never reaches any register.
  assign transfer = data_valid & ~hold_full;

  assign ready   = ~hold_full;
  assign busy    = (state != IDLE) | hold_full;
  assign uart_tx = tx_reg;

  uart_baud_counter u_baud (
    .clk        (clock_12MHz),
    .rst        (reset),
    .load       (baud_load),
    .load_value (BIT_RELOAD),
    .done       (bit_done)
  );

  // FSM state, shifter, bit index and the registered line driver.
  always_ff @(posedge clock_12MHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx_reg  <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      tx_reg  <= tx_next;
    end
  end

  // One-byte holding register between the producer and the shifter.
  always_ff @(posedge clock_12MHz or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      hold      <= hold_next;
      hold_full <= hold_full_next;
    end
  end

  // Next-state and datapath decode; uart_tx is computed one edge ahead so the
  // line changes exactly on the bit-boundary edge with no combinational glitch.
  always_comb begin
    state_next     = state;
    shift_next     = shift;
    bit_idx_next   = bit_idx;
    tx_next        = tx_reg;
    hold_next      = hold;
    hold_full_next = hold_full;
    baud_load      = 1'b0;
    start_frame    = 1'b0;

    // A transfer and a frame load never coincide: one needs hold empty,
    // the other hold full.
    if (transfer) begin
      hold_next      = data;
      hold_full_next = 1'b1;
    end

    unique case (state)
      IDLE: begin
        tx_next     = 1'b1;
        start_frame = hold_full;
      end

      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift[0];
          shift_next   = shift >> 1;
          baud_load    = 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          baud_load = 1'b1;
          if (bit_idx == LAST_DATA) begin
            state_next   = STOP;
            bit_idx_next = '0;
            tx_next      = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift[0];
            shift_next   = shift >> 1;
          end
        end
      end

      STOP: begin
        // bit_idx counts stop bits so each one reuses a single bit period.
        if (bit_done) begin
          if (bit_idx == LAST_STOP) begin
            if (hold_full) begin
              start_frame = 1'b1;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            baud_load    = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Fresh frame from the holding register, either from IDLE or straight
    // out of the last stop bit for back-to-back frames.
    if (start_frame) begin
      state_next     = START;
      shift_next     = hold;
      hold_full_next = 1'b0;
      bit_idx_next   = '0;
      tx_next        = 1'b0;
      baud_load      = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 and 2 stop bits) checked every
// cycle against a frame-timing model, plus a mid-bit sampling receiver and a
// table of hand-computed waveform probes.
module tb_uart_transmitter;

  localparam int C0 = 6;
  localparam int S0 = 1;
  localparam int C1 = 4;
  localparam int S1 = 2;
  localparam int F0 = (9 + S0) * C0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [2];
  logic       dv  [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       txl [2];

  uart_transmitter #(.CLKS_PER_BIT(C0), .STOP_BITS(S0)) dut0 (
    .clock_12MHz (clk),
    .reset       (rst),
    .data        (din[0]),
    .data_valid  (dv[0]),
    .ready       (rdy[0]),
    .busy        (bsy[0]),
    .uart_tx     (txl[0])
  );

  uart_transmitter #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) dut1 (
    .clock_12MHz (clk),
    .reset       (rst),
    .data        (din[1]),
    .data_valid  (dv[1]),
    .ready       (rdy[1]),
    .busy        (bsy[1]),
    .uart_tx     (txl[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level model: when the current frame started, what it carries,
  // and what sits in the holding register.
  int         m_start   [2];
  logic [7:0] m_byte    [2];
  bit         m_hold_v  [2];
  logic [7:0] m_hold_b  [2];
  int         xfer_cnt  [2];
  int         last_xfer [2];
  bit         xv        [2];
  logic [7:0] xd        [2];

  // Mid-bit sampling receiver and the bytes it must see, in order.
  bit         rx_act [2];
  int         rx_s   [2];
  logic [7:0] rx_b   [2];
  logic [7:0] sent_q0 [$];
  logic [7:0] sent_q1 [$];

  typedef struct {
    logic [7:0] byte_val;
    int         offset;
    logic       exp_tx;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [18];

  function automatic int cpb(input int i);
    return (i == 0) ? C0 : C1;
  endfunction

  function automatic int stb(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_start[i]  = -1;
      m_hold_v[i] = 1'b0;
      rx_act[i]   = 1'b0;
    end
    sent_q0.delete();
    sent_q1.delete();
  endtask

  // Advance the model by one edge using the frame rules with plain arithmetic.
  task automatic model_step(input int i);
    int flen;
    flen = (9 + stb(i)) * cpb(i);
    if (m_start[i] >= 0 && cyc - m_start[i] == flen) m_start[i] = -1;
    if (m_start[i] < 0 && m_hold_v[i]) begin
      m_start[i]  = cyc;
      m_byte[i]   = m_hold_b[i];
      m_hold_v[i] = 1'b0;
    end
    if (xv[i]) begin
      m_hold_v[i]  = 1'b1;
      m_hold_b[i]  = xd[i];
      xfer_cnt[i]++;
      last_xfer[i] = cyc;
      if (i == 0) sent_q0.push_back(xd[i]);
      else        sent_q1.push_back(xd[i]);
    end
  endtask

  function automatic logic model_tx(input int i);
    int b;
    if (m_start[i] < 0) return 1'b1;
    b = (cyc - m_start[i]) / cpb(i);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[i][3'(b - 1)];
    return 1'b1;
  endfunction

  task automatic rx_step(input int i);
    int         off;
    int         b;
    int         have;
    logic [7:0] want;
    if (!rx_act[i]) begin
      if (txl[i] === 1'b0) begin
        rx_act[i] = 1'b1;
        rx_s[i]   = cyc;
        rx_b[i]   = '0;
      end
    end else begin
      off = cyc - rx_s[i];
      if (off % cpb(i) == cpb(i) / 2) begin
        b = off / cpb(i);
        if (b == 0) begin
          chk1($sformatf("rx%0d start bit", i), txl[i], 1'b0);
        end else if (b <= 8) begin
          rx_b[i][3'(b - 1)] = txl[i];
        end else begin
          chk1($sformatf("rx%0d stop bit", i), txl[i], 1'b1);
          if (b == 8 + stb(i)) begin
            rx_act[i] = 1'b0;
            have = (i == 0) ? sent_q0.size() : sent_q1.size();
            chk($sformatf("rx%0d frame expected", i), int'(have > 0), 1);
            if (have > 0) begin
              want = (i == 0) ? sent_q0.pop_front() : sent_q1.pop_front();
              chk($sformatf("rx%0d byte", i), int'(rx_b[i]), int'(want));
            end
          end
        end
      end
    end
  endtask

  // One clock: capture inputs at the edge, then update the model and compare
  // every output of both instances shortly after the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      xv[i] = dv[i] && !m_hold_v[i] && !rst;
      xd[i] = din[i];
    end
    cyc++;
    #1;
    if (rst) model_reset();
    for (int i = 0; i < 2; i++) begin
      if (!rst) model_step(i);
      chk($sformatf("cycle %0d dut%0d {tx,ready,busy}", cyc, i),
          int'({txl[i], rdy[i], bsy[i]}),
          int'({model_tx(i), !m_hold_v[i], (m_start[i] >= 0) || m_hold_v[i]}));
      if (!rst) rx_step(i);
    end
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_xfer(input int i, input string name);
    int start;
    int n;
    start = xfer_cnt[i];
    n = 0;
    while (xfer_cnt[i] == start && n < 500) begin
      tick();
      n++;
    end
    chk({name, " accepted"}, int'(xfer_cnt[i] != start), 1);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (((m_start[i] >= 0) || m_hold_v[i]) && n < 40000) begin
      tick();
      n++;
    end
    chk($sformatf("dut%0d reaches idle", i), int'((m_start[i] >= 0) || m_hold_v[i]), 0);
  endtask

  task automatic send_idle(input int i, input logic [7:0] b);
    wait_idle(i);
    din[i] = b;
    dv[i]  = 1'b1;
    wait_xfer(i, $sformatf("send %02h", b));
    dv[i]  = 1'b0;
    din[i] = 'x;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   toggles;
    logic prev0;
    logic prev1;
    int   x1;
    int   x2;
    int   x3;
    int   nxt   [2];
    int   prevc [2];
    int   pct;

    // Probe offsets are counted from the first start-bit cycle, CLKS_PER_BIT=6.
    vecs[0]  = '{8'hA5,  0, 1'b0, 1'b1};
    vecs[1]  = '{8'hA5,  5, 1'b0, 1'b1};
    vecs[2]  = '{8'hA5,  6, 1'b1, 1'b1};
    vecs[3]  = '{8'hA5, 12, 1'b0, 1'b1};
    vecs[4]  = '{8'hA5, 23, 1'b1, 1'b1};
    vecs[5]  = '{8'hA5, 24, 1'b0, 1'b1};
    vecs[6]  = '{8'hA5, 47, 1'b0, 1'b1};
    vecs[7]  = '{8'hA5, 48, 1'b1, 1'b1};
    vecs[8]  = '{8'hA5, 54, 1'b1, 1'b1};
    vecs[9]  = '{8'hA5, 59, 1'b1, 1'b1};
    vecs[10] = '{8'hA5, 60, 1'b1, 1'b0};
    vecs[11] = '{8'h3C,  6, 1'b0, 1'b1};
    vecs[12] = '{8'h3C, 18, 1'b1, 1'b1};
    vecs[13] = '{8'h3C, 41, 1'b1, 1'b1};
    vecs[14] = '{8'h3C, 42, 1'b0, 1'b1};
    vecs[15] = '{8'h01,  6, 1'b1, 1'b1};
    vecs[16] = '{8'h80, 47, 1'b0, 1'b1};
    vecs[17] = '{8'h80, 53, 1'b1, 1'b1};

    model_reset();
    for (int i = 0; i < 2; i++) begin
      dv[i]        = 1'b0;
      din[i]       = 'x;
      xfer_cnt[i]  = 0;
      last_xfer[i] = 0;
    end

    // Reset for three cycles, then the line must sit idle.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk1("after reset tx", txl[0], 1'b1);
    chk1("after reset ready", rdy[0], 1'b1);
    chk1("after reset busy", bsy[0], 1'b0);
    chk1("after reset tx dut1", txl[1], 1'b1);
    toggles = 0;
    prev0 = txl[0];
    prev1 = txl[1];
    for (int n = 0; n < 200; n++) begin
      tick();
      if (txl[0] !== prev0) toggles++;
      if (txl[1] !== prev1) toggles++;
      prev0 = txl[0];
      prev1 = txl[1];
    end
    chk("quiet line toggles", toggles, 0);

    // Waveform probes, one fresh frame per vector.
    for (int v = 0; v < 18; v++) begin
      send_idle(0, vecs[v].byte_val);
      wait_cyc(last_xfer[0] + 1 + vecs[v].offset);
      chk1($sformatf("vec%0d %02h+%0d tx", v, vecs[v].byte_val, vecs[v].offset), txl[0], vecs[v].exp_tx);
      chk1($sformatf("vec%0d %02h+%0d busy", v, vecs[v].byte_val, vecs[v].offset), bsy[0], vecs[v].exp_busy);
    end

    // data_valid held high across 0x00 then 0xFF: no idle gap between frames.
    wait_idle(0);
    din[0] = 8'h00;
    dv[0]  = 1'b1;
    wait_xfer(0, "b2b 00");
    x1 = last_xfer[0];
    din[0] = 8'hFF;
    wait_xfer(0, "b2b FF");
    dv[0]  = 1'b0;
    din[0] = 'x;
    wait_cyc(x1 + F0);
    chk1("b2b last stop cycle", txl[0], 1'b1);
    wait_cyc(x1 + 1 + F0);
    chk1("b2b second start immediate", txl[0], 1'b0);
    wait_cyc(x1 + 2 * F0);
    chk1("b2b busy through 2nd stop", bsy[0], 1'b1);
    wait_cyc(x1 + 1 + 2 * F0);
    chk1("b2b idle after two frames", bsy[0], 1'b0);

    // Three offered bytes: the third waits for the second to load.
    wait_idle(0);
    din[0] = 8'h11;
    dv[0]  = 1'b1;
    wait_xfer(0, "trio 11");
    x1 = last_xfer[0];
    din[0] = 8'h22;
    wait_xfer(0, "trio 22");
    x2 = last_xfer[0];
    chk1("trio ready low after 2nd", rdy[0], 1'b0);
    chk("trio 2nd transfer cycle", x2 - x1, 2);
    din[0] = 8'h33;
    wait_xfer(0, "trio 33");
    x3 = last_xfer[0];
    dv[0]  = 1'b0;
    din[0] = 'x;
    chk("trio 3rd transfer cycle", x3 - x1, F0 + 2);
    wait_idle(0);

    // Reset in the middle of data bit 4 with a byte also waiting in hold.
    send_idle(0, 8'h0F);
    x1 = last_xfer[0];
    din[0] = 8'h77;
    dv[0]  = 1'b1;
    wait_xfer(0, "held 77");
    dv[0]  = 1'b0;
    din[0] = 'x;
    wait_cyc(x1 + 1 + 5 * C0 + 2);
    chk1("mid-frame bit4 before reset", txl[0], 1'b0);
    rst = 1'b1;
    #1;
    chk1("reset forces tx high at once", txl[0], 1'b1);
    chk1("reset empties hold", rdy[0], 1'b1);
    chk1("reset clears busy", bsy[0], 1'b0);
    tick();
    rst = 1'b0;
    tick();
    send_idle(0, 8'h3C);
    wait_idle(0);
    chk("post-reset frame delivered", sent_q0.size(), 0);

    // Sweep every byte value through both configurations.
    for (int i = 0; i < 2; i++) begin
      nxt[i]   = 0;
      prevc[i] = xfer_cnt[i];
      din[i]   = 8'h00;
      dv[i]    = 1'b1;
    end
    for (int n = 0; n < 40000 && (dv[0] || dv[1]); n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (xfer_cnt[i] != prevc[i]) begin
          prevc[i] = xfer_cnt[i];
          nxt[i]++;
          if (nxt[i] == 256) begin
            dv[i]  = 1'b0;
            din[i] = 'x;
          end else begin
            din[i] = 8'(nxt[i]);
          end
        end
      end
    end
    chk("sweep dut0 bytes", nxt[0], 256);
    chk("sweep dut1 bytes", nxt[1], 256);
    wait_idle(0);
    wait_idle(1);

    // Random traffic at light, medium and heavy offered load.
    for (int blk = 0; blk < 6; blk++) begin
      pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 95);
      for (int n = 0; n < 500; n++) begin
        for (int i = 0; i < 2; i++) begin
          dv[i]  = ($urandom_range(0, 99) < pct);
          din[i] = 8'($urandom);
        end
        tick();
      end
    end
    for (int i = 0; i < 2; i++) begin
      dv[i]  = 1'b0;
      din[i] = 'x;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (4) tick();
    chk("dut0 all bytes received", sent_q0.size(), 0);
    chk("dut1 all bytes received", sent_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
